serial_loader: RTL

- Upstream input stage for the 3-bit adder datapath; replaces the ad-hoc button/shift-register pair in front of the adder's A operand.
- Conditions a raw pushbutton: 2-flop sync, counter debounce, rising-edge detect.
- On each press, shifts one synchronized switch bit into a WIDTH-bit parallel word.
- Tracks fill count and flags when a complete word is loaded, so downstream logic and LEDs know the operand is valid.

---
 rtl/serial_loader_pkg.sv | 10 +
 rtl/btn_conditioner.sv | 70 +++++++
 rtl/serial_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_loader_pkg.sv
// rtl/serial_loader_pkg.sv - shared board constants for the serial operand loader
package serial_loader_pkg;

  // Basys3 system clock
  localparam int unsigned BOARD_CLK_HZ = 100_000_000;

  // 10 ms of stable button level at BOARD_CLK_HZ
  localparam int unsigned DEBOUNCE_10MS = BOARD_CLK_HZ / 100;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - pushbutton sync, debounce and press strobe
module btn_conditioner
  import serial_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_meta;
  logic            btn_sync;
  logic            vld_meta;
  logic            sync_vld;
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_level_q;
  logic            armed;

  // Two-flop synchronizer; the valid shadow marks when btn_sync holds a real sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      vld_meta <= 1'b0;
      sync_vld <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      vld_meta <= 1'b1;
      sync_vld <= vld_meta;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= btn_sync;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Edge history, and arming: a button held through reset must be released before it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      db_level_q <= db_level;
      if (sync_vld && !btn_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign press_pulse = armed & db_level & ~db_level_q;

endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - button-clocked serial-to-parallel operand loader
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned CNT_W           = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             si,
  input  logic             clr,
  output logic [WIDTH-1:0] po,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             shift_pulse,
  output logic             load_pulse
);

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

  logic             si_meta;
  logic             si_sync;
  logic             press_pulse;
  logic [WIDTH-1:0] po_d;
  logic [CNT_W-1:0] count_d;
  logic             full_d;
  logic             shift_d;
  logic             load_d;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn),
    .press_pulse(press_pulse)
  );

  // Two-flop synchronizer for the switch bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      si_meta <= 1'b0;
      si_sync <= 1'b0;
    end else begin
      si_meta <= si;
      si_sync <= si_meta;
    end
  end

  // Next word state: clr dominates, a shift while FULL restarts the count at 1.
  always_comb begin
    po_d    = po;
    count_d = count;
    full_d  = full;
    shift_d = 1'b0;
    load_d  = 1'b0;
    if (clr) begin
      po_d    = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (press_pulse) begin
      po_d    = {po[WIDTH-2:0], si_sync};
      shift_d = 1'b1;
      if (count == COUNT_FULL) begin
        count_d = COUNT_ONE;
        full_d  = 1'b0;
      end else begin
        count_d = count + 1'b1;
        if (count == COUNT_LAST) begin
          full_d = 1'b1;
          load_d = 1'b1;
        end
      end
    end
  end

  // Registered word, count and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po          <= '0;
      count       <= '0;
      full        <= 1'b0;
      shift_pulse <= 1'b0;
      load_pulse  <= 1'b0;
    end else begin
      po          <= po_d;
      count       <= count_d;
      full        <= full_d;
      shift_pulse <= shift_d;
      load_pulse  <= load_d;
    end
  end

endmodule
